// File: rtl/fp16_pkg.sv
// FP16 field layout constants and field-extract helpers shared by the multiply arbiter.
package fp16_pkg;

    localparam int unsigned FP16_BIAS  = 15;
    localparam int unsigned FP16_EXP_W = 5;
    localparam int unsigned FP16_MAN_W = 10;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;
    localparam logic [15:0] FP16_POS_INF  = 16'h7C00;

    function automatic logic fp16_sign(input logic [15:0] x);
        return x[15];
    endfunction

    function automatic logic [FP16_EXP_W-1:0] fp16_exp(input logic [15:0] x);
        return x[14:10];
    endfunction

    function automatic logic [FP16_MAN_W-1:0] fp16_man(input logic [15:0] x);
        return x[9:0];
    endfunction

endpackage

// File: rtl/fp16_mul_arbiter_if.sv
// Requester/consumer bundle of the shared FP16 multiplier: operand requests in, tagged products out.
interface fp16_mul_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    i_req;
    logic [NREQ*16-1:0] i_a;
    logic [NREQ*16-1:0] i_b;
    logic [NREQ-1:0]    o_gnt;
    logic               o_vld;
    logic               i_rdy;
    logic [15:0]        o_res;
    logic [IDW-1:0]     o_id;

    modport slave (
        input  i_req, i_a, i_b, i_rdy,
        output o_gnt, o_vld, o_res, o_id
    );

    modport master (
        output i_req, i_a, i_b, i_rdy,
        input  o_gnt, o_vld, o_res, o_id
    );

endinterface

// File: rtl/fp16_mul_core.sv
// Combinational FP16 multiply: truncating mantissa, subnormals flushed to zero, overflow to infinity.
module fp16_mul_core
    import fp16_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_res
);

    logic                  sign;
    logic [FP16_EXP_W-1:0] exp_a;
    logic [FP16_EXP_W-1:0] exp_b;
    logic [21:0]           prod;
    logic signed [7:0]     exp_norm;
    logic [FP16_MAN_W-1:0] man;
    logic                  unused_prod;

    always_comb begin
        sign     = fp16_sign(i_a) ^ fp16_sign(i_b);
        exp_a    = fp16_exp(i_a);
        exp_b    = fp16_exp(i_b);
        prod     = 22'({1'b1, fp16_man(i_a)}) * 22'({1'b1, fp16_man(i_b)});
        // A product of two [1,2) significands lands in [1,4); bit 21 marks the [2,4) half.
        exp_norm = $signed(8'(exp_a) + 8'(exp_b) - 8'(FP16_BIAS) + (prod[21] ? 8'd1 : 8'd0));
        man      = prod[21] ? prod[20:11] : prod[19:10];

        if (exp_a == '0 || exp_b == '0 || exp_norm <= 8'sd0) begin
            o_res = sign ? FP16_NEG_ZERO : FP16_POS_ZERO;
        end else if (exp_norm >= 8'sd31) begin
            o_res = FP16_POS_INF | {sign, 15'h0000};
        end else begin
            o_res = {sign, exp_norm[4:0], man};
        end
    end

    // Low product bits fall below the truncation point.
    assign unused_prod = ^prod[9:0];

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Round-robin shares one FP16 multiplier between NREQ requesters through a two-stage stallable
// pipeline. Define FP16_ARB_STATS_EN to add per-requester 16-bit grant counters (o_gnt_cnt).
module fp16_mul_arbiter
    import fp16_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
`ifdef FP16_ARB_STATS_EN
    output logic [NREQ*16-1:0] o_gnt_cnt,
`endif
    fp16_mul_arbiter_if.slave  bus
);

    logic [NREQ-1:0][15:0] a_arr;
    logic [NREQ-1:0][15:0] b_arr;

    logic [NREQ-1:0] gnt;
    logic            gnt_any;
    logic            gnt_fire;
    logic [IDW-1:0]  gnt_idx;
    logic            adv1;
    logic            adv2;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            s1_vld_q, s1_vld_d;
    logic [15:0]     s1_a_q, s1_a_d;
    logic [15:0]     s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            s2_vld_q, s2_vld_d;
    logic [15:0]     s2_res_q, s2_res_d;
    logic [IDW-1:0]  s2_id_q, s2_id_d;
    logic [15:0]     core_res;

    assign a_arr = bus.i_a;
    assign b_arr = bus.i_b;

    assign adv2     = !s2_vld_q || bus.i_rdy;
    assign adv1     = !s1_vld_q || adv2;
    assign gnt_fire = gnt_any && adv1 && !i_rst;

    // First asserted request at or after ptr, wrapping around.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr_q) + i) % NREQ;
            if (!gnt_any && bus.i_req[IDW'(cand)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(cand);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_fire) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_fire) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_id_d  = s1_id_q;
        s2_vld_d = s2_vld_q;
        s2_res_d = s2_res_q;
        s2_id_d  = s2_id_q;

        if (adv1) begin
            s1_vld_d = gnt_fire;
            if (gnt_fire) begin
                s1_a_d  = a_arr[gnt_idx];
                s1_b_d  = b_arr[gnt_idx];
                s1_id_d = gnt_idx;
            end
        end

        // Payload only moves with a valid entry so the output holds its last product when idle.
        if (adv2) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_res_d = core_res;
                s2_id_d  = s1_id_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_id_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_res_q <= FP16_POS_ZERO;
            s2_id_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_id_q  <= s1_id_d;
            s2_vld_q <= s2_vld_d;
            s2_res_q <= s2_res_d;
            s2_id_q  <= s2_id_d;
        end
    end

    fp16_mul_core u_core (
        .i_a   (s1_a_q),
        .i_b   (s1_b_q),
        .o_res (core_res)
    );

    assign bus.o_gnt = gnt;
    assign bus.o_vld = s2_vld_q;
    assign bus.o_res = s2_res_q;
    assign bus.o_id  = s2_id_q;

`ifdef FP16_ARB_STATS_EN
    logic [NREQ-1:0][15:0] gnt_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (gnt[k]) begin
                    gnt_cnt_q[k] <= gnt_cnt_q[k] + 16'd1;
                end
            end
        end
    end

    assign o_gnt_cnt = gnt_cnt_q;
`endif

endmodule

// File: doc/fp16_mul_arbiter.md
# fp16_mul_arbiter

Shares one combinational FP16 multiply core between `NREQ` requesters with round-robin arbitration, a two-stage register pipeline and valid/ready backpressure on the result side. It sits between several producers of FP16 operand pairs and a single consumer. The consumer receives each product tagged with the index of the requester that issued it.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester tag.

Ports:
- `i_clk`, in, 1: single clock; all state updates on the rising edge.
- `i_rst`, in, 1: reset; synchronous, active-high.
- `i_req`, in, `NREQ`: per-requester request. The operand pair must be held stable while request is high and grant is low.
- `i_a`, in, `NREQ*16`: operand A; requester k uses bits [16k+15:16k].
- `i_b`, in, `NREQ*16`: operand B, same packing as `i_a`.
- `o_gnt`, out, `NREQ`: combinational one-hot accept. The operands of the granted requester are captured this cycle.
- `o_vld`, out, 1: result valid.
- `i_rdy`, in, 1: consumer ready.
- `o_res`, out, 16: FP16 product.
- `o_id`, out, `IDW`: requester index of `o_res`.

## Operation
- Datapath contract (multiply core): sign = sign_a ^ sign_b; exponent = exp_a + exp_b − 15. The mantissa product is {1,mant_a}×{1,mant_b} (22 bits). If product bit 21 is set, shift right 1 and increment the exponent. Mantissa is truncated, with no rounding. If the biased exponent ≤ 0, the result is a signed zero (0x0000 or 0x8000). Subnormal inputs are treated as zero. Exponent overflow (≥31) saturates to signed infinity.
- Arbitration: priority pointer `ptr` in 0..`NREQ`−1. Search runs from `ptr` upward with wrap-around, and the first asserted `i_req` wins.
  - A grant is issued only when stage S1 can accept.
  - After granting k, `ptr` ← (k+1) mod `NREQ`.
  - With no grant, `ptr` holds.
- Pipeline:
  - S1 registers the operands, the id and `s1_vld`.
  - S2 registers the core output, the id and `s2_vld`; `o_vld`=`s2_vld`, `o_res`/`o_id` are driven from S2.
  - Stall: `adv2` = !`s2_vld` | `i_rdy`; `adv1` = !`s1_vld` | `adv2`. A grant is allowed only when `adv1` is high.
  - S2 loads S1 when `adv2`. S1 loads the granted pair when `adv1`; otherwise `s1_vld` clears when advancing.
- Results leave in grant order. Nothing is dropped or duplicated under any `i_rdy` pattern.
- `o_res`/`o_id` stay stable while `o_vld` & !`i_rdy`.

## Timing
- Latency: grant in cycle N → `o_vld` in cycle N+2 when there is no backpressure.
- Throughput: one product per cycle while requests are pending and `i_rdy`=1.
- Reset: `ptr`=0, `s1_vld`=`s2_vld`=0, `o_res`=0x0000, `o_id`=0, `o_gnt`=0 (forced low while `i_rst`).
- Reset mid-operation drops in-flight results. `o_vld` is low in the cycle after `i_rst` is sampled high.
- Simultaneous requests from all requesters with `ptr`=0: grants go 0,1,2,3 on consecutive cycles.
- Full pipeline with `i_rdy`=0: `o_gnt`=0 and both stages hold. The first cycle with `i_rdy`=1 drains S2, advances S1 and grants a new request in the same cycle.
- A requester dropping `i_req` before grant is legal; it is simply not granted.

## Configuration
- `FP16_ARB_STATS_EN` defined: adds output `o_gnt_cnt` [`NREQ*16`]. These are per-requester 16-bit grant counters that increment on each `o_gnt`[k], wrap 0xFFFF→0x0000, and reset to 0.
- `FP16_ARB_STATS_EN` undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Package `fp16_pkg`:
  - Constants `FP16_BIAS`=15, `FP16_EXP_W`=5, `FP16_MAN_W`=10, `FP16_POS_ZERO`=16'h0000, `FP16_NEG_ZERO`=16'h8000, `FP16_POS_INF`=16'h7C00.
  - Field-extract functions for sign/exp/mantissa.
- Sub-module `fp16_mul_core`: purely combinational (`i_a`, `i_b` → `o_res`) per the datapath contract, instantiated once between S1 and S2.

## Test plan
- Single requester 0, `i_a`=0x3C00 (1.0), `i_b`=0x4000 (2.0), `i_rdy`=1 → `o_vld` two cycles after grant, `o_res`=0x4000, `o_id`=0.
- Requester 2 issues 0x3E00×0x3E00 (1.5×1.5) → 0x4080. Requester 1 issues 0xC000×0x4200 → 0xC600. Requester 3 issues 0x0400×0x0400 (underflow) → 0x0000 with FTZ.
- All four requesters requesting continuously from reset with `i_rdy`=1 → grants and `o_id` sequence 0,1,2,3,0,… at one per cycle.
- `i_rdy` held 0 for 5 cycles with requests pending → exactly two results buffered, `o_gnt`=0, `o_res` stable. After release, the results arrive in grant order with no loss.
- `i_rst` pulsed one cycle with S1 and S2 both valid → `o_vld`=0 next cycle, `ptr`=0, and the next grant goes to the lowest requesting index.
- With `FP16_ARB_STATS_EN`: 3 grants to requester 1 → `o_gnt_cnt`[31:16]=3, all other counters 0.
